// File: rtl/mul_seq.sv
// mul_seq: sequential N x N unsigned shift-and-add multiplier controller.
//
// Owns no adder. It steers a shared external N-bit adder through the add_* port,
// one partial-product addition per RUN cycle, and returns a 2N-bit product.
//
// Ports:
//   clk_i       rising-edge clock
//   reset_i     synchronous, active-high reset
//   start_i     multiply request, sampled only in IDLE
//   a_i         multiplicand, captured on the accepting edge
//   b_i         multiplier, captured on the accepting edge
//   busy_o      high in RUN and DONE
//   done_o      one-cycle pulse in DONE
//   product_o   {hi, lo}; valid with done_o and held until the next accepted start
//   add_a_o     adder operand A (hi in RUN, else 0)
//   add_b_o     adder operand B (mcand when lo[0] in RUN, else 0)
//   add_cin_o   adder carry-in, always 0
//   add_sum_i   adder sum, combinational from add_a_o/add_b_o/add_cin_o
//   add_cout_i  adder carry-out
module mul_seq #(
  parameter int unsigned N = 32
) (
  input  logic           clk_i,
  input  logic           reset_i,
  input  logic           start_i,
  input  logic [N-1:0]   a_i,
  input  logic [N-1:0]   b_i,
  output logic           busy_o,
  output logic           done_o,
  output logic [2*N-1:0] product_o,
  output logic [N-1:0]   add_a_o,
  output logic [N-1:0]   add_b_o,
  output logic           add_cin_o,
  input  logic [N-1:0]   add_sum_i,
  input  logic           add_cout_i
);

  localparam int unsigned CntW = $clog2(N) + 1;
  localparam logic [CntW-1:0] CntLast = CntW'(N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StRun,
    StDone
  } state_e;

  state_e          state_q;
  logic [N-1:0]    hi_q;
  logic [N-1:0]    lo_q;
  logic [N-1:0]    mcand_q;
  logic [CntW-1:0] cnt_q;
  logic            busy_q;
  logic            done_q;

  logic            run;

  assign run = (state_q == StRun);

  // Adder operands depend only on registered state, so they change only on edges.
  // Outside RUN the shared adder sees zeros.
  always_comb begin
    add_a_o   = '0;
    add_b_o   = '0;
    add_cin_o = 1'b0;
    if (run) begin
      add_a_o = hi_q;
      add_b_o = lo_q[0] ? mcand_q : '0;
    end
  end

  assign product_o = {hi_q, lo_q};
  assign busy_o    = busy_q;
  assign done_o    = done_q;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q <= StIdle;
      hi_q    <= '0;
      lo_q    <= '0;
      mcand_q <= '0;
      cnt_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (start_i) begin
            hi_q    <= '0;
            lo_q    <= b_i;
            mcand_q <= a_i;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
            state_q <= StRun;
          end
        end
        StRun: begin
          // Shift the (N+1)-bit sum right by one: carry-out lands in hi's MSB,
          // sum LSB becomes the next product low bit as the multiplier shifts out.
          hi_q  <= {add_cout_i, add_sum_i[N-1:1]};
          lo_q  <= {add_sum_i[0], lo_q[N-1:1]};
          cnt_q <= cnt_q + CntW'(1);
          if (cnt_q == CntLast) begin
            done_q  <= 1'b1;
            state_q <= StDone;
          end
        end
        StDone: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
        default: begin
          busy_q  <= 1'b0;
          done_q  <= 1'b0;
          state_q <= StIdle;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_seq.sv
// Self-checking bench for mul_seq: behavioural adder, arithmetic reference model.
module tb_mul_seq;

  logic        clk;
  logic        reset;
  logic        start;
  logic [31:0] a;
  logic [31:0] b;
  logic        busy;
  logic        done;
  logic [63:0] product;
  logic [31:0] add_a;
  logic [31:0] add_b;
  logic        add_cin;
  logic [31:0] add_sum;
  logic        add_cout;

  int vectors;
  int miscompares;

  // Shared adder stand-in.
  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {32'b0, add_cin};

  mul_seq #(.N(32)) dut (
    .clk_i      (clk),
    .reset_i    (reset),
    .start_i    (start),
    .a_i        (a),
    .b_i        (b),
    .busy_o     (busy),
    .done_o     (done),
    .product_o  (product),
    .add_a_o    (add_a),
    .add_b_o    (add_b),
    .add_cin_o  (add_cin),
    .add_sum_i  (add_sum),
    .add_cout_i (add_cout)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // One full operation. Cycle c is the c-th cycle after the accepting edge.
  // pulse1/pulse2: cycles in which start is raised for one cycle (0 = none).
  task automatic do_mul(input logic [31:0] ma, input logic [31:0] mb,
                        input int pulse1, input int pulse2);
    logic [63:0] exp_prod;
    logic [63:0] mask;
    logic [63:0] partial;
    int          done_seen;
    exp_prod  = 64'(ma) * 64'(mb);
    done_seen = 0;
    @(negedge clk);
    a     = ma;
    b     = mb;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    a     = $urandom;
    b     = $urandom;
    for (int c = 1; c <= 34; c++) begin
      if (c > 1) begin
        @(posedge clk);
        #1;
        start = 1'b0;
      end
      if (done === 1'b1) done_seen++;
      if (c <= 32) begin
        // Cycle c consumes multiplier bit c-1; hi holds the upper part of the
        // partial product formed from the bits already consumed.
        mask    = (64'd1 << (c - 1)) - 64'd1;
        partial = (64'(ma) * (64'(mb) & mask)) >> (c - 1);
        if (c == 1 || c == 16 || c == 32) begin
          chk("run_busy", 64'(busy), 64'd1);
          chk("run_done", 64'(done), 64'd0);
        end
        chk("run_add_b", 64'(add_b), mb[c-1] ? 64'(ma) : 64'd0);
        chk("run_add_a", 64'(add_a), 64'(partial[31:0]));
      end else if (c == 33) begin
        chk("done_pulse", 64'(done), 64'd1);
        chk("done_busy", 64'(busy), 64'd1);
        chk("product", product, exp_prod);
        chk("done_add_a", 64'(add_a), 64'd0);
      end else begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_done", 64'(done), 64'd0);
        chk("product_held", product, exp_prod);
        chk("idle_add_b", 64'(add_b), 64'd0);
      end
      if (c == pulse1 || c == pulse2) start = 1'b1;
    end
    chk("done_count", 64'(done_seen), 64'd1);
  endtask

  initial begin
    int done_seen;
    vectors     = 0;
    miscompares = 0;
    reset       = 1'b1;
    start       = 1'b0;
    a           = '0;
    b           = '0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;

    // Reset state and quiet idle.
    for (int i = 0; i < 4; i++) begin
      @(posedge clk);
      #1;
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_done", 64'(done), 64'd0);
      chk("rst_product", product, 64'd0);
      chk("rst_add_a", 64'(add_a), 64'd0);
      chk("rst_add_b", 64'(add_b), 64'd0);
      chk("rst_add_cin", 64'(add_cin), 64'd0);
    end

    do_mul(32'd3, 32'd5, 0, 0);
    do_mul(32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
    do_mul(32'h0, 32'h1234_5678, 0, 0);
    do_mul(32'h89AB_CDEF, 32'h0, 0, 0);
    // Starts raised mid-operation must be ignored.
    do_mul(32'hDEAD_BEEF, 32'h0BAD_F00D, 5, 20);

    // Reset during RUN cycle 10 abandons the operation.
    @(negedge clk);
    a     = $urandom;
    b     = $urandom | 32'h1;
    start = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    for (int c = 2; c <= 10; c++) begin
      @(posedge clk);
      #1;
    end
    chk("pre_rst_busy", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_done", 64'(done), 64'd0);
    chk("midrst_product", product, 64'd0);
    chk("midrst_add_a", 64'(add_a), 64'd0);
    done_seen = 0;
    for (int i = 0; i < 30; i++) begin
      @(posedge clk);
      #1;
      if (done === 1'b1) done_seen++;
    end
    chk("midrst_no_done", 64'(done_seen), 64'd0);
    chk("midrst_idle_busy", 64'(busy), 64'd0);

    do_mul(32'd7, 32'd6, 0, 0);

    // Randomized operands.
    for (int i = 0; i < 6; i++) begin
      do_mul($urandom, $urandom, (i == 2) ? 3 : 0, (i == 4) ? 33 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
